// File: rtl/hilo_mult_unit.sv
// HI/LO special-register unit with an iterative 32x32 shift-add multiplier for mult/multu.
// Define HILO_FWD_EN to bypass pending DONE results and WB writes onto rd_hi/rd_lo in the same cycle.
module hilo_mult_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_hi,
    input  logic        we_lo,
    input  logic [31:0] wdata_hi,
    input  logic [31:0] wdata_lo,
    output logic [31:0] rd_hi,
    output logic [31:0] rd_lo,
    input  logic        mul_start,
    input  logic        mul_signed,
    input  logic [31:0] mul_a,
    input  logic [31:0] mul_b,
    output logic        mul_busy,
    output logic        mul_done,
    output logic        stall_req
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [63:0] r_acc;
    logic [4:0]  r_cnt;
    logic        r_neg;
    logic        r_busy;
    logic        r_done;

    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_sum;
    logic [63:0] w_product;

    // Magnitudes stay 32-bit unsigned, so |0x80000000| = 0x80000000 is exact.
    assign w_abs_a   = (mul_signed && mul_a[31]) ? (~mul_a + 32'd1) : mul_a;
    assign w_abs_b   = (mul_signed && mul_b[31]) ? (~mul_b + 32'd1) : mul_b;
    assign w_sum     = {1'b0, r_acc[63:32]} + (r_mplier[0] ? {1'b0, r_mcand} : 33'd0);
    assign w_product = r_neg ? (~r_acc + 64'd1) : r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_hi     <= '0;
            r_lo     <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            if (we_hi) r_hi <= wdata_hi;
            if (we_lo) r_lo <= wdata_lo;

            // NOTE: the DONE write below is a later non-blocking assignment, so it overrides a same-edge WB write.
            case (r_state)
                S_IDLE: begin
                    if (mul_start) begin
                        r_mcand  <= w_abs_a;
                        r_mplier <= w_abs_b;
                        r_neg    <= mul_signed & (mul_a[31] ^ mul_b[31]);
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc    <= {w_sum, r_acc[31:1]};
                    r_mplier <= {1'b0, r_mplier[31:1]};
                    r_cnt    <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_hi    <= w_product[63:32];
                    r_lo    <= w_product[31:0];
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mul_busy  = r_busy;
    assign mul_done  = r_done;
    assign stall_req = r_busy;

`ifdef HILO_FWD_EN
    assign rd_hi = (r_state == S_DONE) ? w_product[63:32] : (we_hi ? wdata_hi : r_hi);
    assign rd_lo = (r_state == S_DONE) ? w_product[31:0]  : (we_lo ? wdata_lo : r_lo);
`else
    assign rd_hi = r_hi;
    assign rd_lo = r_lo;
`endif

endmodule
